// File: rtl/alu_collect_pkg.sv
// Shared types and the command need-class decode for the ALU operand collector.
package alu_collect_pkg;

  localparam int WIDTH     = 8;
  localparam int CMD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  // Encoding doubles as the operand mask: bit0 = OPA required, bit1 = OPB required.
  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NEED_A  = 2'b01,
    NEED_B  = 2'b10,
    NEED_AB = 2'b11
  } need_e;

  function automatic need_e need_of(input logic mode, input logic [CMD_WIDTH:0] cmd);
    need_e n;
    n = NONE;
    if (mode) begin
      case (int'(cmd))
        0, 1, 2, 3, 8, 9, 10: n = NEED_AB;
        4, 5:                 n = NEED_A;
        6, 7:                 n = NEED_B;
        default:              n = NONE;
      endcase
    end else begin
      case (int'(cmd))
        0, 1, 2, 3, 4, 5, 12, 13: n = NEED_AB;
        6, 8, 9:                  n = NEED_A;
        7, 10, 11:                n = NEED_B;
        default:                  n = NONE;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// Upstream operation stream plus the registered ALU input bundle.
interface alu_operand_collector_if
  import alu_collect_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int CW = CMD_WIDTH
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_opa;
  logic [W-1:0]  in_opb;
  logic [CW:0]   in_cmd;
  logic          in_mode;
  logic          in_cin;
  logic [1:0]    in_inp_valid;

  logic [W-1:0]  OPA;
  logic [W-1:0]  OPB;
  logic [CW:0]   CMD;
  logic          CIN;
  logic          MODE;
  logic          CE;
  logic [1:0]    INP_VALID;
  logic          timeout_err;

  modport master (
    output in_valid, in_opa, in_opb, in_cmd, in_mode, in_cin, in_inp_valid,
    input  in_ready,
    input  OPA, OPB, CMD, CIN, MODE, CE, INP_VALID, timeout_err
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_cmd, in_mode, in_cin, in_inp_valid,
    output in_ready,
    output OPA, OPB, CMD, CIN, MODE, CE, INP_VALID, timeout_err
  );
endinterface

// File: rtl/alu_timeout_ctr.sv
// Saturating wait counter with load-clear; tc flags the last allowed wait cycle.
module alu_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/alu_operand_collector.sv
// Assembles split OPA/OPB beats into one ALU operation and issues it for a single CE cycle.
// state   | meaning
// IDLE    | waiting for the first beat of an operation
// COLLECT | first beat taken, waiting for the missing operand (bounded by TIMEOUT)
// ISSUE   | CE high, output bundle valid, upstream stalled
module alu_operand_collector
  import alu_collect_pkg::*;
#(
  parameter int WIDTH     = alu_collect_pkg::WIDTH,
  parameter int CMD_WIDTH = alu_collect_pkg::CMD_WIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_operand_collector_if.slave  bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [CMD_WIDTH:0] cmd_q, cmd_d;
  logic               mode_q, mode_d, cin_q, cin_d;
  logic [1:0]         have_q, have_d;

  logic [WIDTH-1:0]   out_opa_q, out_opa_d, out_opb_q, out_opb_d;
  logic [CMD_WIDTH:0] out_cmd_q, out_cmd_d;
  logic               out_mode_q, out_mode_d, out_cin_q, out_cin_d;
  logic               ce_q, ce_d, terr_q, terr_d;
  logic [1:0]         out_iv_q, out_iv_d;

  logic               accept, issue, tmo, ctr_clr, ctr_en, ctr_tc;
  logic [1:0]         need_mask;

  alu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    cmd_d      = cmd_q;
    mode_d     = mode_q;
    cin_d      = cin_q;
    have_d     = have_q;
    out_opa_d  = out_opa_q;
    out_opb_d  = out_opb_q;
    out_cmd_d  = out_cmd_q;
    out_mode_d = out_mode_q;
    out_cin_d  = out_cin_q;
    ce_d       = 1'b0;
    out_iv_d   = 2'b00;
    terr_d     = 1'b0;
    issue      = 1'b0;
    tmo        = 1'b0;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    need_mask  = 2'b00;
    accept     = bus.in_valid && (state_q != ISSUE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d     = bus.in_cmd;
          mode_d    = bus.in_mode;
          cin_d     = bus.in_cin;
          opa_d     = bus.in_inp_valid[0] ? bus.in_opa : '0;
          opb_d     = bus.in_inp_valid[1] ? bus.in_opb : '0;
          have_d    = bus.in_inp_valid;
          need_mask = need_of(bus.in_mode, bus.in_cmd);
          if ((have_d & need_mask) == need_mask) begin
            issue = 1'b1;
          end else begin
            state_d = COLLECT;
            ctr_clr = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (bus.in_inp_valid[0]) opa_d = bus.in_opa;
          if (bus.in_inp_valid[1]) opb_d = bus.in_opb;
          have_d = have_q | bus.in_inp_valid;
        end
        need_mask = need_of(mode_q, cmd_q);
        if ((have_d & need_mask) == need_mask) begin
          issue = 1'b1;
        end else if (ctr_tc) begin
          issue = 1'b1;
          tmo   = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ISSUE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output bundle is loaded on the edge entering ISSUE so CE and data line up.
    if (issue) begin
      state_d    = ISSUE;
      out_opa_d  = opa_d;
      out_opb_d  = opb_d;
      out_cmd_d  = cmd_d;
      out_mode_d = mode_d;
      out_cin_d  = cin_d;
      out_iv_d   = have_d;
      ce_d       = 1'b1;
      terr_d     = tmo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      cmd_q      <= '0;
      mode_q     <= 1'b0;
      cin_q      <= 1'b0;
      have_q     <= 2'b00;
      out_opa_q  <= '0;
      out_opb_q  <= '0;
      out_cmd_q  <= '0;
      out_mode_q <= 1'b0;
      out_cin_q  <= 1'b0;
      ce_q       <= 1'b0;
      out_iv_q   <= 2'b00;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      cmd_q      <= cmd_d;
      mode_q     <= mode_d;
      cin_q      <= cin_d;
      have_q     <= have_d;
      out_opa_q  <= out_opa_d;
      out_opb_q  <= out_opb_d;
      out_cmd_q  <= out_cmd_d;
      out_mode_q <= out_mode_d;
      out_cin_q  <= out_cin_d;
      ce_q       <= ce_d;
      out_iv_q   <= out_iv_d;
      terr_q     <= terr_d;
    end
  end

  // Outputs are forced low for the whole time rst is high, not only after its first edge.
  assign bus.in_ready    = !rst && (state_q != ISSUE);
  assign bus.OPA         = rst ? '0 : out_opa_q;
  assign bus.OPB         = rst ? '0 : out_opb_q;
  assign bus.CMD         = rst ? '0 : out_cmd_q;
  assign bus.MODE        = !rst && out_mode_q;
  assign bus.CIN         = !rst && out_cin_q;
  assign bus.CE          = !rst && ce_q;
  assign bus.INP_VALID   = rst ? 2'b00 : out_iv_q;
  assign bus.timeout_err = !rst && terr_q;
endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: single-beat vector table plus split, timeout and reset sequences.
module tb_alu_operand_collector;
  logic clk;
  logic rst;

  alu_operand_collector_if bus ();

  alu_operand_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       mode;
    logic       cin;
    logic [4:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [1:0] iv;
    logic [7:0] eopa;
    logic [7:0] eopb;
    logic [1:0] eiv;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_issue(input string name, input logic [7:0] eopa, input logic [7:0] eopb,
                             input logic [4:0] ecmd, input logic emode, input logic ecin,
                             input logic [1:0] eiv, input logic eterr);
    chk({name, "_ce"},    32'(bus.CE),          32'd1);
    chk({name, "_opa"},   32'(bus.OPA),         32'(eopa));
    chk({name, "_opb"},   32'(bus.OPB),         32'(eopb));
    chk({name, "_cmd"},   32'(bus.CMD),         32'(ecmd));
    chk({name, "_mode"},  32'(bus.MODE),        32'(emode));
    chk({name, "_cin"},   32'(bus.CIN),         32'(ecin));
    chk({name, "_iv"},    32'(bus.INP_VALID),   32'(eiv));
    chk({name, "_terr"},  32'(bus.timeout_err), 32'(eterr));
    chk({name, "_ready"}, 32'(bus.in_ready),    32'd0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ce"},    32'(bus.CE),          32'd0);
    chk({name, "_opa"},   32'(bus.OPA),         32'd0);
    chk({name, "_opb"},   32'(bus.OPB),         32'd0);
    chk({name, "_cmd"},   32'(bus.CMD),         32'd0);
    chk({name, "_mode"},  32'(bus.MODE),        32'd0);
    chk({name, "_cin"},   32'(bus.CIN),         32'd0);
    chk({name, "_iv"},    32'(bus.INP_VALID),   32'd0);
    chk({name, "_terr"},  32'(bus.timeout_err), 32'd0);
    chk({name, "_ready"}, 32'(bus.in_ready),    32'd0);
  endtask

  // Called #1 after an edge; holds the beat across the next edge, then returns #1 after it.
  task automatic beat(input logic mode, input logic cin, input logic [4:0] cmd,
                      input logic [7:0] opa, input logic [7:0] opb, input logic [1:0] iv);
    bus.in_valid     = 1'b1;
    bus.in_mode      = mode;
    bus.in_cin       = cin;
    bus.in_cmd       = cmd;
    bus.in_opa       = opa;
    bus.in_opb       = opb;
    bus.in_inp_valid = iv;
    chk("beat_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    bus.in_inp_valid = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  8'h12, 8'h34, 2'b11, 8'h12, 8'h34, 2'b11};
    vecs[1]  = '{1'b1, 1'b1, 5'd4,  8'h5A, 8'hFF, 2'b01, 8'h5A, 8'h00, 2'b01};
    vecs[2]  = '{1'b1, 1'b0, 5'd15, 8'h77, 8'h88, 2'b00, 8'h00, 8'h00, 2'b00};
    vecs[3]  = '{1'b0, 1'b0, 5'd7,  8'h99, 8'hC3, 2'b10, 8'h00, 8'hC3, 2'b10};
    vecs[4]  = '{1'b0, 1'b1, 5'd12, 8'h0F, 8'hF0, 2'b11, 8'h0F, 8'hF0, 2'b11};
    vecs[5]  = '{1'b1, 1'b0, 5'd6,  8'h21, 8'h44, 2'b10, 8'h00, 8'h44, 2'b10};
    vecs[6]  = '{1'b0, 1'b0, 5'd9,  8'h3C, 8'h55, 2'b01, 8'h3C, 8'h00, 2'b01};
    vecs[7]  = '{1'b1, 1'b1, 5'd4,  8'h81, 8'h7E, 2'b11, 8'h81, 8'h7E, 2'b11};
    vecs[8]  = '{1'b0, 1'b0, 5'd14, 8'hAB, 8'hCD, 2'b01, 8'hAB, 8'h00, 2'b01};
    vecs[9]  = '{1'b1, 1'b0, 5'd16, 8'hE1, 8'hE2, 2'b11, 8'hE1, 8'hE2, 2'b11};
    vecs[10] = '{1'b0, 1'b1, 5'd11, 8'h10, 8'h20, 2'b10, 8'h00, 8'h20, 2'b10};
    vecs[11] = '{1'b1, 1'b0, 5'd11, 8'h10, 8'h20, 2'b00, 8'h00, 8'h00, 2'b00};

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_opa       = '0;
    bus.in_opb       = '0;
    bus.in_cmd       = '0;
    bus.in_mode      = 1'b0;
    bus.in_cin       = 1'b0;
    bus.in_inp_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset_ce",    32'(bus.CE),       32'd0);

    for (int i = 0; i < 12; i++) begin
      beat(vecs[i].mode, vecs[i].cin, vecs[i].cmd, vecs[i].opa, vecs[i].opb, vecs[i].iv);
      check_issue($sformatf("vec%0d", i), vecs[i].eopa, vecs[i].eopb, vecs[i].cmd,
                  vecs[i].mode, vecs[i].cin, vecs[i].eiv, 1'b0);
      step();
      chk($sformatf("vec%0d_ce_drop", i), 32'(bus.CE),        32'd0);
      chk($sformatf("vec%0d_iv_drop", i), 32'(bus.INP_VALID), 32'd0);
      chk($sformatf("vec%0d_hold",    i), 32'(bus.OPA),       32'(vecs[i].eopa));
      chk($sformatf("vec%0d_ready",   i), 32'(bus.in_ready),  32'd1);
    end

    // OPA and OPB in separate beats with idle gap
    beat(1'b1, 1'b0, 5'd0, 8'hA5, 8'h00, 2'b01);
    seen = (bus.CE === 1'b1) ? 1 : 0;
    repeat (5) begin
      step();
      if (bus.CE === 1'b1) seen++;
    end
    chk("split_early_ce", 32'(seen), 32'd0);
    beat(1'b1, 1'b0, 5'd0, 8'h00, 8'h0F, 2'b10);
    check_issue("split", 8'hA5, 8'h0F, 5'd0, 1'b1, 1'b0, 2'b11, 1'b0);
    step();
    chk("split_ce_drop", 32'(bus.CE), 32'd0);

    // Missing operand never arrives: 16 COLLECT cycles then partial issue
    beat(1'b0, 1'b0, 5'd0, 8'h5B, 8'h77, 2'b01);
    n = 0;
    while (bus.CE !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd16);
    check_issue("timeout", 8'h5B, 8'h00, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1);
    step();
    chk("timeout_pulse_drop", 32'(bus.timeout_err), 32'd0);
    chk("timeout_ce_drop",    32'(bus.CE),          32'd0);

    // Completing beat lands in the last allowed COLLECT cycle
    beat(1'b1, 1'b0, 5'd1, 8'h3D, 8'h00, 2'b01);
    seen = 0;
    repeat (15) begin
      step();
      if (bus.CE === 1'b1) seen++;
    end
    chk("boundary_early_ce", 32'(seen), 32'd0);
    beat(1'b1, 1'b0, 5'd1, 8'h00, 8'hC2, 2'b10);
    check_issue("boundary", 8'h3D, 8'hC2, 5'd1, 1'b1, 1'b0, 2'b11, 1'b0);
    step();

    // Overwrite, ignored cmd/mode/cin in COLLECT, and an empty beat
    beat(1'b1, 1'b0, 5'd0, 8'h11, 8'h00, 2'b01);
    beat(1'b0, 1'b1, 5'd3, 8'h22, 8'hFF, 2'b01);
    chk("overwrite_mid_ce", 32'(bus.CE), 32'd0);
    beat(1'b0, 1'b1, 5'd9, 8'hEE, 8'hEE, 2'b00);
    chk("empty_beat_ce", 32'(bus.CE), 32'd0);
    beat(1'b1, 1'b1, 5'd5, 8'h00, 8'h33, 2'b10);
    check_issue("overwrite", 8'h22, 8'h33, 5'd0, 1'b1, 1'b0, 2'b11, 1'b0);
    step();

    // Reset while collecting at cnt=7 discards the operation
    beat(1'b1, 1'b0, 5'd2, 8'h66, 8'h00, 2'b01);
    repeat (7) step();
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    step();
    check_zero("rst_mid_edge");
    rst = 1'b0;
    #1;
    chk("rst_mid_opa_cleared", 32'(bus.OPA), 32'd0);
    seen = 0;
    repeat (20) begin
      step();
      if (bus.CE === 1'b1 || bus.timeout_err === 1'b1) seen++;
    end
    chk("rst_mid_no_issue", 32'(seen), 32'd0);
    beat(1'b1, 1'b0, 5'd1, 8'h9A, 8'hBC, 2'b11);
    check_issue("after_rst", 8'h9A, 8'hBC, 5'd1, 1'b1, 1'b0, 2'b11, 1'b0);
    step();
    chk("after_rst_ce_drop", 32'(bus.CE), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
